// File: rtl/projectile_engine_pkg.sv
// Shared definitions for the artillery projectile engine: state encoding,
// fixed-point widths and the Q0.8 trig table (6 degree steps, 0..90 deg).
package projectile_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLIGHT = 2'd1,
    RESULT = 2'd2
  } projState_t;

  localparam int XFP_W  = 16;  // Q10.6 unsigned column
  localparam int YFP_W  = 17;  // Q11.6 signed height
  localparam int VX_W   = 9;
  localparam int VY_W   = 10;
  localparam int FRAC_W = 6;

  // round(255*cos(6*idx deg)); index 15 (90 deg) falls to the zero default
  function automatic logic [7:0] cosRom(input logic [3:0] idx);
    logic [7:0] val;
    case (idx)
      4'd0:    val = 8'd255;
      4'd1:    val = 8'd254;
      4'd2:    val = 8'd249;
      4'd3:    val = 8'd243;
      4'd4:    val = 8'd233;
      4'd5:    val = 8'd221;
      4'd6:    val = 8'd206;
      4'd7:    val = 8'd190;
      4'd8:    val = 8'd171;
      4'd9:    val = 8'd150;
      4'd10:   val = 8'd128;
      4'd11:   val = 8'd104;
      4'd12:   val = 8'd79;
      4'd13:   val = 8'd53;
      4'd14:   val = 8'd27;
      default: val = 8'd0;
    endcase
    return val;
  endfunction

  // sin(6i) = cos(90 - 6i) = cos(6*(15-i))
  function automatic logic [7:0] sinRom(input logic [3:0] idx);
    return cosRom(4'd15 - idx);
  endfunction

endpackage

// File: rtl/projectile_engine_button_debouncer.sv
// Two-flop synchroniser and stable-count debouncer for a raw push-button;
// emits a one-cycle pulse on each debounced rising edge.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btnRaw,
  output logic risePulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_r;
  logic             sync_r;
  logic             stable_r;
  logic             rise_r;
  logic [CNT_W-1:0] cnt_r;

  // metastability synchroniser for the asynchronous button
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= btnRaw;
      sync_r <= meta_r;
    end
  end

  // accept a new level only after it has differed for DEBOUNCE_CYCLES in a row
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_r <= 1'b0;
      rise_r   <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      rise_r <= 1'b0;
      if (sync_r != stable_r) begin
        if (cnt_r == CNT_LAST) begin
          stable_r <= sync_r;
          rise_r   <= sync_r;
          cnt_r    <= {CNT_W{1'b0}};
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end else begin
        cnt_r <= {CNT_W{1'b0}};
      end
    end
  end

  assign risePulse = rise_r;

endmodule

// File: rtl/projectile_engine.sv
// Artillery game logic: debounced launch, per-frame fixed-point ballistic
// integration, hit detection and saturating score, all outputs registered.
module projectile_engine
  import projectile_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int X0              = 32,
  parameter int GROUND_Y        = 440,
  parameter int X_MAX           = 640,
  parameter int GRAV            = 2,
  parameter int HIT_TOL         = 8,
  parameter int RESULT_FRAMES   = 60
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        launch_btn,
  input  logic [7:0]  power_in,
  input  logic [7:0]  angle_in,
  input  logic        frame_tick,
  input  logic [9:0]  target_x,
  output logic [9:0]  proj_x,
  output logic [9:0]  proj_y,
  output logic        proj_active,
  output logic        hit,
  output logic [15:0] score,
  output logic [1:0]  state
);

  localparam int RF_W = $clog2(RESULT_FRAMES + 1);
  localparam logic [XFP_W-1:0] X0_FP     = XFP_W'(X0 * 64);
  localparam logic [XFP_W-1:0] XMAX_FP   = XFP_W'(X_MAX * 64);
  localparam logic [15:0]      SCORE_MAX = 16'd9999;
  localparam logic [RF_W-1:0]  RF_LAST   = RF_W'(RESULT_FRAMES - 1);

  projState_t              state_r;
  projState_t              nextState_s;
  logic [XFP_W-1:0]        xFp_r;
  logic signed [YFP_W-1:0] yFp_r;
  logic [VX_W-1:0]         vx_r;
  logic signed [VY_W-1:0]  vy_r;
  logic [RF_W-1:0]         frameCnt_r;
  logic [15:0]             score_r;
  logic                    hitPulse_r;

  logic                    launchPulse_s;
  logic                    launch_s;
  logic                    step_s;
  logic                    scoreHit_s;
  logic [15:0]             cosProd_s;
  logic [15:0]             sinProd_s;
  logic [XFP_W-1:0]        xNext_s;
  logic signed [YFP_W-1:0] yNext_s;
  logic                    landed_s;
  logic                    missed_s;
  logic signed [10:0]      xDiff_s;
  logic [10:0]             xDist_s;
  logic                    onTarget_s;
  logic                    lastFrame_s;
  logic                    unusedAngle_s;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk      (clk),
    .reset_n  (reset_n),
    .btnRaw   (launch_btn),
    .risePulse(launchPulse_s)
  );

  assign unusedAngle_s = ^angle_in[3:0];

  // launch velocity products and one integration step
  always_comb begin
    cosProd_s   = {8'd0, power_in} * {8'd0, cosRom(angle_in[7:4])};
    sinProd_s   = {8'd0, power_in} * {8'd0, sinRom(angle_in[7:4])};
    xNext_s     = xFp_r + {7'd0, vx_r};
    yNext_s     = yFp_r + {{7{vy_r[VY_W-1]}}, vy_r};
    landed_s    = yNext_s[YFP_W-1];
    missed_s    = (xNext_s >= XMAX_FP);
    xDiff_s     = {1'b0, xNext_s[15:6]} - {1'b0, target_x};
    xDist_s     = xDiff_s[10] ? (11'd0 - xDiff_s) : xDiff_s;
    onTarget_s  = (xDist_s <= 11'(HIT_TOL));
    lastFrame_s = (frameCnt_r == RF_LAST);
  end

  // next-state and control decode
  always_comb begin
    nextState_s = state_r;
    launch_s    = 1'b0;
    step_s      = 1'b0;
    scoreHit_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (launchPulse_s) begin
          launch_s    = 1'b1;
          nextState_s = FLIGHT;
        end else begin
          nextState_s = IDLE;
        end
      end
      FLIGHT: begin
        if (frame_tick) begin
          step_s = 1'b1;
          // a miss takes precedence over a simultaneous landing
          scoreHit_s = landed_s & ~missed_s & onTarget_s;
          if (landed_s || missed_s) begin
            nextState_s = RESULT;
          end else begin
            nextState_s = FLIGHT;
          end
        end else begin
          nextState_s = FLIGHT;
        end
      end
      RESULT: begin
        if (frame_tick && lastFrame_s) begin
          nextState_s = IDLE;
        end else begin
          nextState_s = RESULT;
        end
      end
      default: nextState_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // trajectory integrator and result frame counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xFp_r      <= X0_FP;
      yFp_r      <= {YFP_W{1'b0}};
      vx_r       <= {VX_W{1'b0}};
      vy_r       <= {VY_W{1'b0}};
      frameCnt_r <= {RF_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (launch_s) begin
            vx_r  <= {1'b0, cosProd_s[15:8]};
            vy_r  <= {2'b00, sinProd_s[15:8]};
            xFp_r <= X0_FP;
            yFp_r <= {YFP_W{1'b0}};
          end
        end
        FLIGHT: begin
          if (step_s) begin
            xFp_r <= xNext_s;
            vy_r  <= vy_r - 10'(GRAV);
            if (landed_s && !missed_s) begin
              yFp_r <= {YFP_W{1'b0}};
            end else begin
              yFp_r <= yNext_s;
            end
          end
        end
        RESULT: begin
          if (frame_tick) begin
            if (lastFrame_s) begin
              frameCnt_r <= {RF_W{1'b0}};
              xFp_r      <= X0_FP;
              yFp_r      <= {YFP_W{1'b0}};
            end else begin
              frameCnt_r <= frameCnt_r + RF_W'(1);
            end
          end
        end
        default: begin
          frameCnt_r <= {RF_W{1'b0}};
        end
      endcase
    end
  end

  // hit pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hitPulse_r <= 1'b0;
    end else begin
      hitPulse_r <= scoreHit_s;
    end
  end

  // saturating score counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      score_r <= 16'd0;
    end else if (scoreHit_s && (score_r != SCORE_MAX)) begin
      score_r <= score_r + 16'd1;
    end
  end

  // registered outputs, one cycle behind the internal state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      proj_x      <= 10'(X0);
      proj_y      <= 10'(GROUND_Y);
      proj_active <= 1'b0;
      hit         <= 1'b0;
      score       <= 16'd0;
      state       <= 2'd0;
    end else begin
      proj_x      <= xFp_r[15:6];
      proj_y      <= 10'(GROUND_Y) - yFp_r[15:6];
      proj_active <= (state_r == FLIGHT);
      hit         <= hitPulse_r;
      score       <= score_r;
      state       <= state_r;
    end
  end

endmodule

// File: tb/tb_projectile_engine.sv
// Self-checking bench for projectile_engine: randomized and directed shots
// compared against a closed-form ballistic model.
module tb_projectile_engine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        launch_btn;
  logic [7:0]  power_in;
  logic [7:0]  angle_in;
  logic        frame_tick;
  logic [9:0]  target_x;
  logic [9:0]  proj_x;
  logic [9:0]  proj_y;
  logic        proj_active;
  logic        hit;
  logic [15:0] score;
  logic [1:0]  state;

  localparam real PI = 3.141592653589793;

  int nChecks = 0;
  int nFail = 0;
  int modelScore = 0;
  int tickCnt = 0;

  int obsEntries, obsTicks, obsResFrames, obsPeak, obsHits;
  int obsResX, obsResY, obsIdleX, obsIdleY, obsScore;
  bit obsTimeout, obsRelaunch;

  int mTicks, mLandX, mFinalY, mPeak;
  bit mHit;

  projectile_engine #(
    .DEBOUNCE_CYCLES(4),
    .RESULT_FRAMES  (3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .launch_btn (launch_btn),
    .power_in   (power_in),
    .angle_in   (angle_in),
    .frame_tick (frame_tick),
    .target_x   (target_x),
    .proj_x     (proj_x),
    .proj_y     (proj_y),
    .proj_active(proj_active),
    .hit        (hit),
    .score      (score),
    .state      (state)
  );

  always #5 clk = ~clk;

  // one frame_tick every 16 cycles
  initial begin
    frame_tick = 1'b0;
    forever begin
      @(negedge clk);
      tickCnt = (tickCnt + 1) % 16;
      frame_tick = (tickCnt == 15);
    end
  end

  // closed-form ballistic model in 1/64 px units
  task automatic model_shot(input int pw, input int ang, input int tgt);
    int idx, cs, sn, vx, vy, x, h, d;
    real rad;
    bit done;
    idx = ang / 16;
    rad = 6.0 * idx * PI / 180.0;
    cs = int'(255.0 * $cos(rad));
    sn = int'(255.0 * $sin(rad));
    vx = (pw * cs) / 256;
    vy = (pw * sn) / 256;
    mPeak = 440;
    mHit = 1'b0;
    done = 1'b0;
    for (int n = 1; n < 2000 && !done; n++) begin
      x = 2048 + n * vx;
      h = n * vy - n * (n - 1);
      if (x >= 640 * 64) begin
        done = 1'b1; mTicks = n; mLandX = x / 64; mFinalY = 440 - h / 64;
      end else if (h < 0) begin
        done = 1'b1; mTicks = n; mLandX = x / 64; mFinalY = 440;
        d = mLandX - tgt;
        mHit = (d <= 8) && (d >= -8);
      end else if (440 - h / 64 < mPeak) begin
        mPeak = 440 - h / 64;
      end
    end
    if (mFinalY < mPeak) mPeak = mFinalY;
    if (mHit && modelScore < 9999) modelScore++;
  endtask

  // drive one shot and record what the outputs did (no checking here)
  task automatic do_shot(input int pw, input int ang, input int tgt, input bit pressMid);
    logic [1:0] st, prevSt;
    bit prevTick;
    int phase, flightIt;
    power_in = 8'(pw); angle_in = 8'(ang); target_x = 10'(tgt);
    obsEntries = 0; obsTicks = 0; obsResFrames = 0; obsPeak = 1023; obsHits = 0;
    obsResX = -1; obsResY = -1; obsIdleX = -1; obsIdleY = -1; obsScore = -1;
    obsTimeout = 1'b0; obsRelaunch = 1'b0;
    prevTick = 1'b0; prevSt = 2'd0; phase = 0; flightIt = 0;
    for (int it = 0; it < 6000 && phase < 3; it++) begin
      @(negedge clk); #1;
      st = state;
      if (st == 2'd1 && prevSt != 2'd1) obsEntries++;
      if (st == 2'd1 && prevTick) obsTicks++;
      if (st == 2'd2 && prevTick) obsResFrames++;
      if ((st == 2'd1 || st == 2'd2) && int'(proj_y) < obsPeak) obsPeak = int'(proj_y);
      if (hit) obsHits++;
      if (st == 2'd2 && prevSt == 2'd1) begin obsResX = proj_x; obsResY = proj_y; end
      if (st == 2'd1) begin phase = (phase == 0) ? 1 : phase; flightIt++; end
      if (st == 2'd2) phase = 2;
      if (st == 2'd0 && phase == 2) begin
        phase = 3; obsIdleX = proj_x; obsIdleY = proj_y; obsScore = score;
      end
      prevTick = frame_tick;
      prevSt = st;
      launch_btn = (it < 10) || (pressMid && flightIt >= 100 && flightIt < 130);
    end
    launch_btn = 1'b0;
    if (phase != 3) obsTimeout = 1'b1;
    repeat (24) begin
      @(negedge clk); #1;
      if (state != 2'd0) obsRelaunch = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; launch_btn = 1'b0; power_in = 8'd0; angle_in = 8'd0; target_x = 10'd0;
    repeat (3) @(negedge clk);
    #1;
    nChecks++; if (proj_x !== 10'd32) begin nFail++; $display("FAIL reset_proj_x: got %0d expected 32", proj_x); end
    nChecks++; if (proj_y !== 10'd440) begin nFail++; $display("FAIL reset_proj_y: got %0d expected 440", proj_y); end
    nChecks++; if (proj_active !== 1'b0) begin nFail++; $display("FAIL reset_active: got %0b expected 0", proj_active); end
    nChecks++; if (hit !== 1'b0) begin nFail++; $display("FAIL reset_hit: got %0b expected 0", hit); end
    nChecks++; if (score !== 16'd0) begin nFail++; $display("FAIL reset_score: got %0d expected 0", score); end
    nChecks++; if (state !== 2'd0) begin nFail++; $display("FAIL reset_state: got %0d expected 0", state); end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_flight;
    int waitN;
    power_in = 8'd200; angle_in = 8'h80; target_x = 10'd0;
    launch_btn = 1'b1;
    repeat (10) @(negedge clk);
    launch_btn = 1'b0;
    waitN = 0;
    while (state != 2'd1 && waitN < 60) begin @(negedge clk); waitN++; end
    nChecks++; if (state !== 2'd1) begin nFail++; $display("FAIL midreset_launch: got state %0d expected 1", state); end
    repeat (40) @(negedge clk);
    reset_n = 1'b0;
    #1;
    nChecks++; if (state !== 2'd0) begin nFail++; $display("FAIL midreset_state: got %0d expected 0", state); end
    nChecks++; if (proj_x !== 10'd32) begin nFail++; $display("FAIL midreset_proj_x: got %0d expected 32", proj_x); end
    nChecks++; if (proj_active !== 1'b0) begin nFail++; $display("FAIL midreset_active: got %0b expected 0", proj_active); end
    nChecks++; if (score !== 16'd0) begin nFail++; $display("FAIL midreset_score: got %0d expected 0", score); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    nChecks++; if (state !== 2'd0) begin nFail++; $display("FAIL midreset_stays_idle: got %0d expected 0", state); end
  endtask

  task automatic test_bounce;
    bit left;
    left = 1'b0;
    for (int g = 0; g < 6; g++) begin
      launch_btn = 1'b1;
      repeat (2) @(negedge clk);
      launch_btn = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (30) begin
      @(negedge clk); #1;
      if (state != 2'd0 || proj_active) left = 1'b1;
    end
    nChecks++; if (left !== 1'b0) begin nFail++; $display("FAIL bounce_no_launch: got %0b expected 0", left); end
  endtask

  task automatic test_flat_hit;
    model_shot(255, 8'h00, 39);
    do_shot(255, 8'h00, 39, 1'b0);
    nChecks++; if (obsTimeout !== 1'b0) begin nFail++; $display("FAIL flat_timeout: got %0b expected 0", obsTimeout); end
    nChecks++; if (obsEntries !== 1) begin nFail++; $display("FAIL flat_entries: got %0d expected 1", obsEntries); end
    nChecks++; if (obsTicks !== 2) begin nFail++; $display("FAIL flat_ticks: got %0d expected 2", obsTicks); end
    nChecks++; if (obsResX !== 39) begin nFail++; $display("FAIL flat_land_x: got %0d expected 39", obsResX); end
    nChecks++; if (obsHits !== 1) begin nFail++; $display("FAIL flat_hit_pulse: got %0d expected 1", obsHits); end
    nChecks++; if (obsScore !== modelScore) begin nFail++; $display("FAIL flat_score: got %0d expected %0d", obsScore, modelScore); end
    nChecks++; if (obsResFrames !== 3) begin nFail++; $display("FAIL flat_result_frames: got %0d expected 3", obsResFrames); end
    nChecks++; if (obsIdleX !== 32 || obsIdleY !== 440) begin nFail++; $display("FAIL flat_idle_pos: got (%0d,%0d) expected (32,440)", obsIdleX, obsIdleY); end
    nChecks++; if (obsRelaunch !== 1'b0) begin nFail++; $display("FAIL flat_relaunch: got %0b expected 0", obsRelaunch); end
  endtask

  task automatic test_vertical;
    model_shot(128, 8'hF0, 100);
    do_shot(128, 8'hF0, 100, 1'b0);
    nChecks++; if (obsTimeout !== 1'b0) begin nFail++; $display("FAIL vert_timeout: got %0b expected 0", obsTimeout); end
    nChecks++; if (obsTicks !== mTicks || obsTicks !== 129) begin nFail++; $display("FAIL vert_ticks: got %0d expected %0d", obsTicks, mTicks); end
    nChecks++; if (obsPeak !== mPeak || obsPeak !== 376) begin nFail++; $display("FAIL vert_peak: got %0d expected %0d", obsPeak, mPeak); end
    nChecks++; if (obsResX !== 32) begin nFail++; $display("FAIL vert_land_x: got %0d expected 32", obsResX); end
    nChecks++; if (obsResY !== 440) begin nFail++; $display("FAIL vert_land_y: got %0d expected 440", obsResY); end
    nChecks++; if (obsHits !== 0) begin nFail++; $display("FAIL vert_no_hit: got %0d expected 0", obsHits); end
    nChecks++; if (obsScore !== modelScore) begin nFail++; $display("FAIL vert_score: got %0d expected %0d", obsScore, modelScore); end
  endtask

  task automatic test_long_shot_presses;
    model_shot(255, 8'h70, 300);
    do_shot(255, 8'h70, 300, 1'b1);
    nChecks++; if (obsTimeout !== 1'b0) begin nFail++; $display("FAIL long_timeout: got %0b expected 0", obsTimeout); end
    nChecks++; if (obsEntries !== 1) begin nFail++; $display("FAIL long_entries: got %0d expected 1", obsEntries); end
    nChecks++; if (obsTicks !== mTicks) begin nFail++; $display("FAIL long_ticks: got %0d expected %0d", obsTicks, mTicks); end
    nChecks++; if (obsResX !== mLandX) begin nFail++; $display("FAIL long_land_x: got %0d expected %0d", obsResX, mLandX); end
    nChecks++; if (obsResY !== mFinalY) begin nFail++; $display("FAIL long_land_y: got %0d expected %0d", obsResY, mFinalY); end
    nChecks++; if (obsPeak !== mPeak) begin nFail++; $display("FAIL long_peak: got %0d expected %0d", obsPeak, mPeak); end
    nChecks++; if (obsScore !== modelScore) begin nFail++; $display("FAIL long_score: got %0d expected %0d", obsScore, modelScore); end
    nChecks++; if (obsRelaunch !== 1'b0) begin nFail++; $display("FAIL long_press_discarded: got %0b expected 0", obsRelaunch); end
  endtask

  task automatic test_random;
    int pw, ang, tgt;
    for (int k = 0; k < 5; k++) begin
      pw = $urandom_range(40, 255);
      ang = $urandom_range(0, 255);
      model_shot(pw, ang, 0);
      if (mHit) modelScore--;
      tgt = mLandX + $urandom_range(0, 24) - 12;
      model_shot(pw, ang, tgt);
      do_shot(pw, ang, tgt, 1'b0);
      nChecks++; if (obsTimeout !== 1'b0) begin nFail++; $display("FAIL rnd%0d_timeout: got %0b expected 0", k, obsTimeout); end
      nChecks++; if (obsEntries !== 1) begin nFail++; $display("FAIL rnd%0d_entries: got %0d expected 1", k, obsEntries); end
      nChecks++; if (obsTicks !== mTicks) begin nFail++; $display("FAIL rnd%0d_ticks: got %0d expected %0d", k, obsTicks, mTicks); end
      nChecks++; if (obsResX !== mLandX) begin nFail++; $display("FAIL rnd%0d_land_x: got %0d expected %0d", k, obsResX, mLandX); end
      nChecks++; if (obsResY !== mFinalY) begin nFail++; $display("FAIL rnd%0d_land_y: got %0d expected %0d", k, obsResY, mFinalY); end
      nChecks++; if (obsPeak !== mPeak) begin nFail++; $display("FAIL rnd%0d_peak: got %0d expected %0d", k, obsPeak, mPeak); end
      nChecks++; if (obsHits !== int'(mHit)) begin nFail++; $display("FAIL rnd%0d_hits: got %0d expected %0d", k, obsHits, mHit); end
      nChecks++; if (obsScore !== modelScore) begin nFail++; $display("FAIL rnd%0d_score: got %0d expected %0d", k, obsScore, modelScore); end
      nChecks++; if (obsResFrames !== 3) begin nFail++; $display("FAIL rnd%0d_result_frames: got %0d expected 3", k, obsResFrames); end
      nChecks++; if (obsIdleX !== 32 || obsIdleY !== 440) begin nFail++; $display("FAIL rnd%0d_idle_pos: got (%0d,%0d) expected (32,440)", k, obsIdleX, obsIdleY); end
    end
  endtask

  task automatic test_score_saturation;
    @(negedge clk);
    force dut.score_r = 16'd9998;
    @(negedge clk);
    release dut.score_r;
    modelScore = 9998;
    for (int k = 0; k < 2; k++) begin
      model_shot(255, 8'h00, 39);
      do_shot(255, 8'h00, 39, 1'b0);
      nChecks++; if (obsTimeout !== 1'b0) begin nFail++; $display("FAIL sat%0d_timeout: got %0b expected 0", k, obsTimeout); end
      nChecks++; if (obsHits !== 1) begin nFail++; $display("FAIL sat%0d_hit_pulse: got %0d expected 1", k, obsHits); end
      nChecks++; if (obsScore !== modelScore || obsScore !== 9999) begin nFail++; $display("FAIL sat%0d_score: got %0d expected %0d", k, obsScore, modelScore); end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_flight();
    test_bounce();
    test_flat_hit();
    test_vertical();
    test_long_shot_presses();
    test_random();
    test_score_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
